ldpc_3gpp_dec_llr_read_sched: RTL and testbench
===============================================

// Module: ldpc_3gpp_dec_LLR_read_sched
// PURPOSE
//  Sequencer driving the LLR read address generator for one decoder half-iteration.
//  On istart it latches zc/row configuration and emits the read beat stream with
//  strobes and per-row masks in node order:
//   - cnode: horizontal, zc beats per row group.
//   - vnode: vertical, row-group beats per zc index.
//  Drains for the generator+RAM latency, then pulses odone.
// PARAMETERS
//  pROW_BY_CYCLE  8  rows processed per beat (mask width)
//  pROW_W         6  width of row count (rows up to 46)
//  pDRAIN         4  read latency to drain (2 addr gen + 2 ram) before odone
// PORTS
//  iclk       in   1              clock
//  ireset     in   1              reset, asynchronous, active-high
//  iclkena    in   1              clock enable; low freezes all state/outputs
//  istart     in   1              start pulse; ignored unless idle
//  ic_nv_mode in   1              1 = cnode order, 0 = vnode order; latched at istart
//  iused_zc   in   hb_zc_t        lifting size; latched at istart
//  iused_row  in   pROW_W         active rows; latched at istart; 0 treated as 1
//  iready     in   1              downstream ready; low stalls beat issue
//  oread      out  1              read beat valid (to generator iread)
//  orstart    out  1              1-cycle pulse with first beat of frame
//  ostrb      out  strb_t         sof/sop/eop/eof of current beat
//  omask      out  [pROW_BY_CYCLE] per-row valid mask of current beat
//  obusy      out  1              high from istart accept until odone inclusive
//  odone      out  1              1-cycle pulse after last beat + pDRAIN cycles
// BEHAVIOUR
//  - Reset: state IDLE. oread, orstart, ostrb, omask, obusy, odone all 0; counters 0.
//  - Derived values (latched at istart):
//    - ngrp = ceil(max(iused_row,1)/pROW_BY_CYCLE).
//    - cnode: ngrp packets x zc beats.
//    - vnode: zc packets x ngrp beats.
//  - Counters:
//    - grp_cnt (0..ngrp-1), zc_cnt (0..zc-1); inner/outer role swaps with mode.
//    - Inner wraps to 0 and advances outer.
//  - Strobes, registered, aligned to oread:
//    - sop = inner==0; eop = inner==last.
//    - sof = sop of first packet; eof = eop of last packet.
//  - Mask: omask[i] = (grp_cnt*pROW_BY_CYCLE + i) < used_row; both modes.
//  - FSM:
//    - IDLE  -> RUN    on istart (1-cycle config latch; first beat next cycle).
//    - RUN   -> DRAIN  after the eof beat is issued.
//    - DRAIN -> DONE   after pDRAIN cycles.
//    - DONE  -> IDLE   next cycle; odone=1 for that one cycle.
//  - Handshake: in RUN a beat issues (oread=1, counters advance) only when iready=1.
//    iready=0 drives oread=0 with counters, strobes and mask held. No bubbles when
//    iready stays high.
//  - Latency: first oread 2 cycles after istart. Total cycles to odone =
//    2 + beats + stall cycles + pDRAIN.
//  - Boundaries:
//    - zc=1 (cnode) or ngrp=1 (vnode): each beat has sop&eop.
//    - Single beat total (zc=1, rows<=pROW_BY_CYCLE): sof&sop&eop&eof together.
//    - zc counter wraps at zc-1 exactly (no power-of-2 assumption).
//    - istart during busy is ignored; config is not updated.
//    - iclkena=0 in any state holds everything; DRAIN count does not advance.
//    - Reset mid-operation aborts to IDLE; odone is not pulsed.
//  - Widths: zc compare uses hb_zc_t. grp*pROW_BY_CYCLE+i is computed at pROW_W+1
//    bits to avoid overflow.
// STRUCTURE
//  - Shared package (ldpc_3gpp_dec_types.svh): strb_t, hb_zc_t, pROW_BY_CYCLE.
//  - Local: FSM enum {IDLE,RUN,DRAIN,DONE}.
//  - One sub-module: ldpc_3gpp_dec_nest_cnt, a 2-level wrap counter with
//    first/last flags. Used for inner/outer in both modes.
// TESTING
//  - cnode, zc=4, rows=10, iready=1:
//    - 2 packets x 4 beats.
//    - masks 8'hFF then 8'h03.
//    - sof on beat0, eof on beat7.
//    - odone 2+8+4 cycles after istart.
//  - vnode, zc=3, rows=20:
//    - 3 packets x 3 beats.
//    - mask per beat FF, FF, 0F repeating.
//    - sop/eop on beats 0/2 of each packet.
//  - zc=1, rows=5, cnode: single beat with sof=sop=eop=eof=1, mask 8'h1F.
//  - iready toggled 1010... in cnode zc=5, rows=8:
//    - beats, strobes and masks identical to the unstalled run.
//    - odone delayed by stall count.
//  - istart reasserted mid-RUN: ignored. Reset asserted mid-RUN: outputs 0
//    immediately; no odone pulse; a new istart runs cleanly.
//  - iclkena low 3 cycles during DRAIN: odone delayed exactly 3 cycles.

Source files
------------

// File: rtl/ldpc_3gpp_dec_llr_read_sched_pkg.sv
// Shared types for the LLR read scheduler: lifting-size type, beat strobes
// and the number of rows handled per beat.
package ldpc_3gpp_dec_llr_read_sched_pkg;

    localparam int pROW_BY_CYCLE = 8;
    localparam int cZC_W         = 9;

    typedef logic [cZC_W-1:0] hb_zc_t;

    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

endpackage

// File: rtl/ldpc_3gpp_dec_llr_read_sched_nest_cnt.sv
// Two-level wrap counter: the inner level wraps at iinner_last and carries into
// the outer level, which wraps at iouter_last. Flags mark first/last values.
module ldpc_3gpp_dec_llr_read_sched_nest_cnt
    import ldpc_3gpp_dec_llr_read_sched_pkg::*;
(
    input  logic   iclk,
    input  logic   ireset,
    input  logic   iclkena,
    input  logic   iclr,
    input  logic   iadv,
    input  hb_zc_t iinner_last,
    input  hb_zc_t iouter_last,
    output hb_zc_t oinner,
    output hb_zc_t oouter,
    output logic   oinner_first,
    output logic   oinner_last,
    output logic   oouter_first,
    output logic   oouter_last
);

    hb_zc_t inner_q;
    hb_zc_t outer_q;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            inner_q <= '0;
            outer_q <= '0;
        end else if (iclkena) begin
            if (iclr) begin
                inner_q <= '0;
                outer_q <= '0;
            end else if (iadv) begin
                if (inner_q == iinner_last) begin
                    inner_q <= '0;
                    outer_q <= (outer_q == iouter_last) ? '0 : outer_q + hb_zc_t'(1);
                end else begin
                    inner_q <= inner_q + hb_zc_t'(1);
                end
            end
        end
    end

    assign oinner       = inner_q;
    assign oouter       = outer_q;
    assign oinner_first = (inner_q == '0);
    assign oinner_last  = (inner_q == iinner_last);
    assign oouter_first = (outer_q == '0);
    assign oouter_last  = (outer_q == iouter_last);

endmodule

// File: rtl/ldpc_3gpp_dec_llr_read_sched.sv
// LLR read beat sequencer for one decoder half-iteration: emits beats with
// strobes and row masks in cnode or vnode order, drains, then pulses odone.
module ldpc_3gpp_dec_llr_read_sched
    import ldpc_3gpp_dec_llr_read_sched_pkg::*;
#(
    parameter int pROW_W = 6,
    parameter int pDRAIN = 4
)
(
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iclkena,
    input  logic                     istart,
    input  logic                     ic_nv_mode,
    input  hb_zc_t                   iused_zc,
    input  logic [pROW_W-1:0]        iused_row,
    input  logic                     iready,
    output logic                     oread,
    output logic                     orstart,
    output strb_t                    ostrb,
    output logic [pROW_BY_CYCLE-1:0] omask,
    output logic                     obusy,
    output logic                     odone
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int RW = pROW_W + 1;
    localparam int DW = $clog2(pDRAIN + 1) + 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(pDRAIN);

    state_t              state_q, state_d;
    logic                mode_q;
    hb_zc_t              zc_last_q, ngrp_last_q;
    logic [pROW_W-1:0]   used_row_q;
    logic [DW-1:0]       drain_cnt_q;

    logic [pROW_W-1:0]   row_eff;
    hb_zc_t              zc_eff;
    logic [RW-1:0]       ngrp;
    logic                accept, issue;

    hb_zc_t              inner, outer, inner_last_v, outer_last_v, grp;
    logic                inner_first, inner_last, outer_first, outer_last;
    strb_t               beat_strb;
    logic [RW-1:0]       row_base;
    logic [pROW_BY_CYCLE-1:0] beat_mask;

    assign accept = (state_q == IDLE) && istart;
    assign issue  = (state_q == RUN) && iready;

    // Zero-sized configurations are run as a single row / single zc index.
    always_comb begin
        row_eff = (iused_row == '0) ? pROW_W'(1) : iused_row;
        zc_eff  = (iused_zc == '0) ? hb_zc_t'(1) : iused_zc;
        ngrp    = ({1'b0, row_eff} + RW'(pROW_BY_CYCLE - 1)) / RW'(pROW_BY_CYCLE);
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            mode_q      <= 1'b0;
            zc_last_q   <= '0;
            ngrp_last_q <= '0;
            used_row_q  <= '0;
        end else if (iclkena && accept) begin
            mode_q      <= ic_nv_mode;
            zc_last_q   <= zc_eff - hb_zc_t'(1);
            ngrp_last_q <= hb_zc_t'(ngrp) - hb_zc_t'(1);
            used_row_q  <= row_eff;
        end
    end

    // cnode walks zc inside each row group; vnode walks row groups inside each zc.
    assign inner_last_v = mode_q ? zc_last_q : ngrp_last_q;
    assign outer_last_v = mode_q ? ngrp_last_q : zc_last_q;

    ldpc_3gpp_dec_llr_read_sched_nest_cnt u_cnt (
        .iclk         (iclk),
        .ireset       (ireset),
        .iclkena      (iclkena),
        .iclr         (accept),
        .iadv         (issue),
        .iinner_last  (inner_last_v),
        .iouter_last  (outer_last_v),
        .oinner       (inner),
        .oouter       (outer),
        .oinner_first (inner_first),
        .oinner_last  (inner_last),
        .oouter_first (outer_first),
        .oouter_last  (outer_last)
    );

    assign grp      = mode_q ? outer : inner;
    assign row_base = RW'(grp) * RW'(pROW_BY_CYCLE);

    always_comb begin
        beat_strb.sof = inner_first && outer_first;
        beat_strb.sop = inner_first;
        beat_strb.eop = inner_last;
        beat_strb.eof = inner_last && outer_last;
        for (int i = 0; i < pROW_BY_CYCLE; i++) begin
            beat_mask[i] = (row_base + RW'(i)) < {1'b0, used_row_q};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (istart) state_d = RUN;
            RUN:     if (issue && beat_strb.eof) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // DRAIN also covers the cycle in which the last beat is presented.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else if (iclkena) begin
            state_q     <= state_d;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DW'(1) : '0;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oread   <= 1'b0;
            orstart <= 1'b0;
            ostrb   <= '0;
            omask   <= '0;
        end else if (iclkena) begin
            oread   <= issue;
            orstart <= issue && beat_strb.sof;
            if (issue) begin
                ostrb <= beat_strb;
                omask <= beat_mask;
            end
        end
    end

    assign obusy = (state_q != IDLE);
    assign odone = (state_q == DONE);

endmodule

// File: tb/tb_ldpc_3gpp_dec_llr_read_sched.sv
// Randomized/directed bench for the LLR read scheduler against a beat-list
// reference model built from the node-order rules.
module tb_ldpc_3gpp_dec_llr_read_sched;
    import ldpc_3gpp_dec_llr_read_sched_pkg::*;

    localparam int ROW_W = 6;
    localparam int DRAIN = 4;

    logic iclk = 1'b0;
    logic ireset, iclkena, istart, ic_nv_mode, iready;
    hb_zc_t iused_zc;
    logic [ROW_W-1:0] iused_row;
    logic oread, orstart, obusy, odone;
    strb_t ostrb;
    logic [pROW_BY_CYCLE-1:0] omask;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] strb;
        logic [7:0] mask;
    } beat_t;

    beat_t exp_q[$];

    ldpc_3gpp_dec_llr_read_sched #(.pROW_W(ROW_W), .pDRAIN(DRAIN)) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .istart     (istart),
        .ic_nv_mode (ic_nv_mode),
        .iused_zc   (iused_zc),
        .iused_row  (iused_row),
        .iready     (iready),
        .oread      (oread),
        .orstart    (orstart),
        .ostrb      (ostrb),
        .omask      (omask),
        .obusy      (obusy),
        .odone      (odone)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat list: packets are row groups (cnode) or zc indices (vnode).
    task automatic build_model(input logic mode, input int zc, input int rows);
        int r, ngrp, npk, nin, g;
        beat_t b;
        exp_q.delete();
        r    = (rows == 0) ? 1 : rows;
        ngrp = (r + 7) / 8;
        npk  = mode ? ngrp : zc;
        nin  = mode ? zc : ngrp;
        for (int p = 0; p < npk; p++) begin
            for (int j = 0; j < nin; j++) begin
                g = mode ? p : j;
                for (int i = 0; i < 8; i++) b.mask[i] = ((g * 8 + i) < r);
                b.strb = {(p == 0 && j == 0), (j == 0), (j == nin - 1),
                          (p == npk - 1 && j == nin - 1)};
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic run(input logic mode, input int zc, input int rows,
                       input int stall_kind, input bit gap, input int restart_at);
        int B, k, issued, stalls, gaps, drain_left, done_k;
        logic cur_rdy, cur_en, exp_read, exp_rstart;
        beat_t eb;
        build_model(mode, zc, rows);
        B = exp_q.size();
        k = 0; issued = 0; stalls = 0; gaps = 0; drain_left = -1; done_k = -1;
        exp_read = 1'b0; exp_rstart = 1'b0; eb = '0;
        @(negedge iclk);
        ic_nv_mode = mode;
        iused_zc   = hb_zc_t'(zc);
        iused_row  = ROW_W'(rows);
        istart     = 1'b1;
        iready     = 1'b1;
        iclkena    = 1'b1;
        cur_rdy    = 1'b1;
        cur_en     = 1'b1;
        while (done_k < 0 && k < 3000) begin
            @(negedge iclk);
            k++;
            istart = 1'b0;
            if (k >= 2 && cur_en) begin
                if (issued < B) begin
                    if (cur_rdy) begin
                        exp_read   = 1'b1;
                        eb         = exp_q.pop_front();
                        exp_rstart = (issued == 0);
                        issued++;
                        if (issued == B) drain_left = DRAIN + 1;
                    end else begin
                        exp_read   = 1'b0;
                        exp_rstart = 1'b0;
                        stalls++;
                    end
                end else begin
                    exp_read   = 1'b0;
                    exp_rstart = 1'b0;
                    if (drain_left > 0) drain_left--;
                end
            end
            chk("oread", oread, exp_read);
            chk("orstart", orstart, exp_rstart);
            if (exp_read) begin
                chk("strobes", {ostrb.sof, ostrb.sop, ostrb.eop, ostrb.eof}, eb.strb);
                chk("mask", omask, eb.mask);
            end
            chk("obusy", obusy, 1'b1);
            chk("odone", odone, drain_left == 0);
            if (drain_left == 0) done_k = k;
            case (stall_kind)
                1:       cur_rdy = (k % 2 == 1);
                2:       cur_rdy = 1'($urandom_range(0, 1));
                default: cur_rdy = 1'b1;
            endcase
            cur_en = 1'b1;
            if (gap && drain_left == 2 && gaps < 3) begin
                cur_en = 1'b0;
                gaps++;
            end
            iready  = cur_rdy;
            iclkena = cur_en;
            if (restart_at == k) begin
                istart    = 1'b1;
                iused_zc  = hb_zc_t'(zc + 3);
                iused_row = ROW_W'(rows + 9);
            end
        end
        chk("done_seen", done_k >= 0, 1'b1);
        chk("total_cycles", done_k, 2 + B + stalls + DRAIN + (gap ? 3 : 0));
        @(negedge iclk);
        iclkena = 1'b1;
        chk("odone_clear", odone, 1'b0);
        chk("idle_busy", obusy, 1'b0);
    endtask

    initial begin
        ireset = 1'b1; iclkena = 1'b1; istart = 1'b0; ic_nv_mode = 1'b0;
        iready = 1'b0; iused_zc = '0; iused_row = '0;
        repeat (2) @(negedge iclk);
        chk("rst_oread", oread, 1'b0);
        chk("rst_orstart", orstart, 1'b0);
        chk("rst_ostrb", ostrb, 4'h0);
        chk("rst_omask", omask, 8'h00);
        chk("rst_obusy", obusy, 1'b0);
        chk("rst_odone", odone, 1'b0);
        ireset = 1'b0;

        run(1'b1, 4, 10, 0, 1'b0, -1);
        run(1'b0, 3, 20, 0, 1'b0, -1);
        run(1'b1, 1, 5, 0, 1'b0, -1);
        run(1'b1, 5, 8, 0, 1'b0, -1);
        run(1'b1, 5, 8, 1, 1'b0, -1);
        run(1'b1, 5, 8, 0, 1'b0, 3);
        run(1'b0, 4, 12, 0, 1'b1, -1);
        run(1'b0, 1, 46, 1, 1'b0, -1);

        @(negedge iclk);
        ic_nv_mode = 1'b1; iused_zc = hb_zc_t'(6); iused_row = ROW_W'(30);
        istart = 1'b1; iready = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        repeat (4) @(negedge iclk);
        ireset = 1'b1;
        #1;
        chk("abort_oread", oread, 1'b0);
        chk("abort_orstart", orstart, 1'b0);
        chk("abort_ostrb", ostrb, 4'h0);
        chk("abort_omask", omask, 8'h00);
        chk("abort_obusy", obusy, 1'b0);
        chk("abort_odone", odone, 1'b0);
        repeat (2) @(negedge iclk);
        ireset = 1'b0;
        repeat (8) begin
            @(negedge iclk);
            chk("abort_no_done", odone, 1'b0);
            chk("abort_idle", obusy, 1'b0);
        end
        run(1'b0, 7, 33, 2, 1'b0, -1);

        for (int n = 0; n < 6; n++) begin
            run(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)),
                int'($urandom_range(0, 46)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
